// File: rtl/serial_word_loader_pkg.sv
// Shared types for the serial word loader: FSM state encoding and default word width.
// The PARITY state exists only when SERIAL_WORD_LOADER_PARITY_EN is defined.
package serial_word_loader_pkg;

  localparam int DEFAULT_WIDTH = 4;

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE   = 2'd2,
    PARITY = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// Saturating bit counter for the serial word loader; tc flags that the next
// accepted bit is the final data bit of the word.
module bit_counter #(
  parameter int MAX   = 4,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(MAX - 1));

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader: collects WIDTH bits MSB-first and pulses load with D.
// Optional even-parity check enabled by SERIAL_WORD_LOADER_PARITY_EN.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] D,
  output logic             load,
  output logic             busy,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             err_q, err_d;
  logic             cnt_clr, cnt_inc, cnt_tc;

  bit_counter #(
    .MAX (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (reset),
    .clear (cnt_clr),
    .inc   (cnt_inc),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    d_d     = d_q;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
          sr_d    = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_clr = 1'b1;
          sr_d    = '0;
        end else if (sin_valid) begin
          sr_d    = {sr_q[WIDTH-2:0], sin};
          cnt_inc = 1'b1;
          if (cnt_tc) begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            state_d = PARITY;
`else
            // D is staged on the edge entering DONE so it changes with load.
            state_d = DONE;
            d_d     = {sr_q[WIDTH-2:0], sin};
`endif
          end
        end
      end
`ifdef SERIAL_WORD_LOADER_PARITY_EN
      PARITY: begin
        if (start) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
          sr_d    = '0;
        end else if (sin_valid) begin
          if (sin == ^sr_q) begin
            state_d = DONE;
            d_d     = sr_q;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      d_q     <= d_d;
      err_q   <= err_d;
    end
  end

  assign D    = d_q;
  assign load = (state_q == DONE);
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  assign busy = (state_q == SHIFT) || (state_q == PARITY);
  assign err  = err_q;
`else
  assign busy = (state_q == SHIFT);
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed self-checking bench for serial_word_loader with a downstream enable register.
module tb_serial_word_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sin;
  logic       sin_valid;
  logic [3:0] D;
  logic       load;
  logic       busy;
  logic       err;

  logic [3:0] ds_q = 4'h0;
  int         load_cnt = 0;
  int         err_cnt = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         base;

  serial_word_loader #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sin       (sin),
    .sin_valid (sin_valid),
    .D         (D),
    .load      (load),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load === 1'b1) begin
      ds_q     <= D;
      load_cnt <= load_cnt + 1;
    end
    if (err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic v, input logic b);
    start     = st;
    sin_valid = v;
    sin       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    #2;
    chk("rst_D", D, 4'h0);
    chk("rst_load", load, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // reset mid-frame after two bits
    step(1, 0, 0);
    chk("mf_busy_start", busy, 1'b1);
    step(0, 1, 1);
    step(0, 1, 1);
    reset = 1'b0;
    #1;
    chk("mf_D", D, 4'h0);
    chk("mf_busy", busy, 1'b0);
    chk("mf_load", load, 1'b0);
    @(posedge clk); #1;
    chk("mf_load2", load, 1'b0);
    reset = 1'b1;

    // first start honoured, bits 1101 back-to-back
    base = load_cnt;
    step(1, 0, 0);
    chk("b2b_busy_start", busy, 1'b1);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 0);
    chk("b2b_busy_mid", busy, 1'b1);
    chk("b2b_noload_mid", load, 1'b0);
    step(0, 1, 1);
    chk("b2b_load", load, 1'b1);
    chk("b2b_D", D, 4'hD);
    chk("b2b_busy_done", busy, 1'b0);
    step(0, 0, 0);
    chk("b2b_load_off", load, 1'b0);
    chk("b2b_D_hold", D, 4'hD);
    chk("b2b_ds", ds_q, 4'hD);
    chk("b2b_load_count", load_cnt - base, 1);

    // valid strobe in IDLE is ignored
    step(0, 1, 0);
    chk("idle_D_hold", D, 4'hD);
    chk("idle_busy", busy, 1'b0);

    // bits 0010 with 3-cycle gaps
    base = load_cnt;
    step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      chk("gap_busy", busy, 1'b1);
    end
    step(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      chk("gap_load", load, 1'b0);
    end
    step(0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      chk("gap_busy2", busy, 1'b1);
    end
    chk("gap_D_unchanged", D, 4'hD);
    step(0, 1, 0);
    chk("gap_load_pulse", load, 1'b1);
    chk("gap_D", D, 4'h2);
    step(0, 0, 0);
    chk("gap_ds", ds_q, 4'h2);
    chk("gap_load_count", load_cnt - base, 1);

    // restart after three bits; valid bit on the restart cycle is ignored
    base = load_cnt;
    step(1, 0, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    chk("rs_busy", busy, 1'b1);
    chk("rs_noload", load, 1'b0);
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("rs_noload_mid", load, 1'b0);
    step(0, 1, 0);
    chk("rs_load", load, 1'b1);
    chk("rs_D", D, 4'h8);
    // start during DONE is ignored
    step(1, 0, 0);
    chk("done_start_busy", busy, 1'b0);
    chk("done_start_load", load, 1'b0);
    chk("rs_ds", ds_q, 4'h8);
    chk("rs_load_count", load_cnt - base, 1);
    step(0, 0, 0);
    chk("done_start_idle", busy, 1'b0);

`ifdef SERIAL_WORD_LOADER_PARITY_EN
    // good parity: 0101 + 0
    base = load_cnt;
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("par_busy", busy, 1'b1);
    chk("par_noload", load, 1'b0);
    step(0, 1, 0);
    chk("par_load", load, 1'b1);
    chk("par_D", D, 4'h5);
    step(0, 0, 0);
    chk("par_ds", ds_q, 4'h5);
    // bad parity: 1111 + 1
    step(1, 0, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    chk("perr_err", err, 1'b1);
    chk("perr_load", load, 1'b0);
    chk("perr_D", D, 4'h5);
    chk("perr_busy", busy, 1'b0);
    step(0, 0, 0);
    chk("perr_err_off", err, 1'b0);
    chk("perr_load_count", load_cnt - base, 1);
    chk("perr_err_count", err_cnt, 1);
`else
    chk("noparity_err_count", err_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_word_loader.md
SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the word width in bits delivered to the downstream parallel register.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, frame-start request.
REQ-005 The block SHALL have port sin, input, 1 bit, serial data bit, sampled only when sin_valid=1.
REQ-006 The block SHALL have port sin_valid, input, 1 bit, serial bit strobe.
REQ-007 The block SHALL have port D, output, WIDTH bits, last completed word, wired to the downstream register data input.
REQ-008 The block SHALL have port load, output, 1 bit, one-cycle pulse, wired to the downstream register enable.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a frame is being received.
REQ-010 The block SHALL have port err, output, 1 bit, one-cycle pulse on a rejected frame.

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT, PARITY, DONE.
REQ-012 In IDLE, start=1 at a clock edge SHALL move to SHIFT, clear the bit counter and clear the shift register.
REQ-013 In SHIFT, each edge with sin_valid=1 SHALL shift sin into the shift register MSB-first and increment the bit counter; edges with sin_valid=0 SHALL hold all state.
REQ-014 When the WIDTH-th bit is accepted, the FSM SHALL go to PARITY if PARITY_EN is defined, otherwise to DONE.
REQ-015 In DONE, D SHALL take the shift-register value and load SHALL be 1 for exactly that one cycle, then the FSM SHALL return to IDLE.
REQ-016 D SHALL therefore change in the same cycle load is high, and D SHALL hold its value at all other times.
REQ-017 Latency SHALL be one cycle from acceptance of the last data or parity bit to the load pulse.
REQ-018 busy SHALL be 1 in SHIFT and PARITY and 0 in IDLE and DONE.
REQ-019 start=1 in SHIFT or PARITY SHALL restart the frame by clearing the counter and shift register and staying in or returning to SHIFT; any sin_valid in that same cycle SHALL be ignored.
REQ-020 start=1 in DONE SHALL be ignored; the load pulse completes normally.
REQ-021 The bit counter SHALL be clog2(WIDTH+1) bits wide and SHALL never wrap; it clears on frame start.

Reset
REQ-022 reset=0 SHALL asynchronously force state IDLE, D=0, load=0, busy=0, err=0, counter=0 and shift register=0.
REQ-023 Reset asserted mid-frame SHALL discard the partial word with no load or err pulse.
REQ-024 After reset deasserts, the first start SHALL be honoured on the first following rising edge.

Configuration
REQ-025 With macro SERIAL_WORD_LOADER_PARITY_EN defined, the PARITY state SHALL accept one further sin_valid bit as even parity over the data bits.
REQ-026 When that parity bit is correct, the FSM SHALL go to DONE.
REQ-027 When that parity bit is wrong, err SHALL be 1 for one cycle, D SHALL be unchanged, load SHALL stay 0 and the FSM SHALL return to IDLE.
REQ-028 Without the macro, the PARITY state and parity logic SHALL not exist and err SHALL be tied to 0.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration and the default-width constant 4.
REQ-030 The bit counter SHALL be a separate sub-module, bit_counter, with clear, increment and terminal-count output.
REQ-031 No other sub-module SHALL be used.

Verification
REQ-032 Verification SHALL check: reset=0 mid-frame after 2 bits -> D=0000, no load, busy=0 immediately.
REQ-033 Verification SHALL check: start, then bits 1,1,0,1 on consecutive valid cycles -> one cycle later D=1101, load=1 for one cycle, busy falls.
REQ-034 Verification SHALL check: start, then bits 0,0,1,0 with sin_valid=0 gaps of 3 cycles between bits -> D=0010, load once, busy held high across the gaps.
REQ-035 Verification SHALL check: start, bits 1,1,1, then start again, then 1,0,0,0 -> D=1000, exactly one load pulse.
REQ-036 Verification SHALL check, with PARITY_EN: bits 0,1,0,1 plus parity 0 -> D=0101 and load; then 1,1,1,1 plus parity 1 -> err pulse, D stays 0101, no load.
REQ-037 Verification SHALL check: downstream register with enable=load -> its output matches D one edge after each load pulse.
